multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences IDLE/FETCH/LOAD/EXEC/STORE/HALT and drives
// datapath enables, bus mux select and the extended immediate from the latched instruction.
module multicycle_control_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_ADDR_W = 3,
  parameter int IMM_SIGNED = 1,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [15:0]             instruction,
  output logic                    en_i,
  output logic                    en_s,
  output logic                    en_c,
  output logic [2**REG_ADDR_W-1:0] en_reg,
  output logic [2:0]              sel,
  output logic [REG_ADDR_W:0]     mux_sel,
  output logic [DATA_WIDTH-1:0]   imm_val,
  output logic                    done,
  output logic                    busy,
  output logic                    halted,
  output logic                    illegal,
  output logic [CNT_W-1:0]        instr_count
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int IMM_W    = 11 - REG_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_STORE, S_HALT
  } state_t;

  state_t          r_state;
  logic [15:0]     r_instr_q;
  logic [CNT_W-1:0] r_instr_count;

  logic [1:0]            w_fmt;
  logic [2:0]            w_alu;
  logic [REG_ADDR_W-1:0] w_rx;
  logic [REG_ADDR_W-1:0] w_ry;
  logic [IMM_W-1:0]      w_imm;
  logic [DATA_WIDTH-1:0] w_imm_ext;

  assign w_fmt = r_instr_q[1:0];
  assign w_alu = r_instr_q[4:2];
  assign w_rx  = r_instr_q[15 -: REG_ADDR_W];
  assign w_ry  = r_instr_q[15-REG_ADDR_W -: REG_ADDR_W];
  assign w_imm = r_instr_q[15-REG_ADDR_W -: IMM_W];

  generate
    if (IMM_SIGNED != 0) begin : g_sext
      assign w_imm_ext = {{(DATA_WIDTH-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    end else begin : g_zext
      assign w_imm_ext = {{(DATA_WIDTH-IMM_W){1'b0}}, w_imm};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_instr_q     <= '0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (run) r_state <= S_FETCH;
        S_FETCH: begin
          r_instr_q <= instruction;
          r_state   <= S_LOAD;
        end
        S_LOAD:  r_state <= S_EXEC;
        S_EXEC:  r_state <= (w_fmt == 2'b10) ? S_HALT : S_STORE;
        S_STORE: begin
          r_instr_count <= r_instr_count + CNT_W'(1);
          r_state       <= run ? S_FETCH : S_IDLE;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_count = r_instr_count;

  // Moore decode: outputs depend only on the state and the latched instruction.
  always_comb begin
    en_i    = 1'b0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    en_reg  = '0;
    sel     = '0;
    mux_sel = '1;
    imm_val = '0;
    done    = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        en_i = 1'b1;
        busy = 1'b1;
      end
      S_LOAD: begin
        en_s    = 1'b1;
        mux_sel = {1'b0, w_rx};
        busy    = 1'b1;
      end
      S_EXEC: begin
        busy = 1'b1;
        case (w_fmt)
          2'b00: begin
            en_c    = 1'b1;
            mux_sel = {1'b0, w_ry};
            sel     = w_alu;
          end
          2'b01: begin
            en_c    = 1'b1;
            mux_sel = {1'b1, {REG_ADDR_W{1'b0}}};
            sel     = w_alu;
            imm_val = w_imm_ext;
          end
          2'b11:   illegal = 1'b1;
          default: ;
        endcase
      end
      S_STORE: begin
        busy = 1'b1;
        done = 1'b1;
        if (!w_fmt[1]) en_reg[w_rx] = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
